// File: rtl/ofdm_symbol_streamer.sv
// rtl/ofdm_symbol_streamer.sv - streams a captured OFDM frame from the CP-removal buffer to the FFT stage
module ofdm_symbol_streamer #(
  parameter int FFT_POINT  = 64,
  parameter int CE_SYM_NUM = 4,
  parameter int SYM_NUM    = 12,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              buf_full,
  output logic [ADDR_W-1:0] rd_ptr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              frame_done,
  output logic [3:0]        sym_idx
);

  localparam int LOG2_FFT = $clog2(FFT_POINT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_POINT * SYM_NUM - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STREAM   = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_WAIT_CLR = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_beat;
  logic              r_inflight;
  logic [7:0]        r_mem0;
  logic [7:0]        r_mem1;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_issue;
  logic              w_clr;
  logic [2:0]        w_occ;
  logic [3:0]        w_sym;

  assign m_tvalid = (r_count != 2'd0);
  assign w_pop    = m_tvalid & m_tready;

  // Occupancy after this edge's pop; counting the pop keeps full rate with only 2 entries.
  assign w_occ   = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = (r_state == S_STREAM) && (w_occ < 3'd2);
  assign w_clr   = (r_state == S_IDLE) || ((r_state == S_WAIT_CLR) && !buf_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (buf_full) r_state <= S_STREAM;
        S_STREAM:   if (w_issue && (r_rd_ptr == LAST_ADDR)) r_state <= S_DRAIN;
        S_DRAIN:    if (w_pop && (r_beat == LAST_ADDR)) r_state <= S_DONE;
        S_DONE:     r_state <= S_WAIT_CLR;
        S_WAIT_CLR: if (!buf_full) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_clr) begin
        r_rd_ptr <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_clr) begin
        r_beat <= '0;
      end else if (w_pop) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Skid FIFO: the read issued last edge always returns now, so push = r_inflight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0   <= 8'd0;
      r_mem1   <= 8'd0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_inflight) begin
        if (r_wr_sel) begin
          r_mem1 <= rd_data;
        end else begin
          r_mem0 <= rd_data;
        end
        r_wr_sel <= ~r_wr_sel;
      end
      if (w_pop) begin
        r_rd_sel <= ~r_rd_sel;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign w_sym      = 4'(r_beat >> LOG2_FFT);
  assign m_tdata    = r_rd_sel ? r_mem1 : r_mem0;
  assign m_tlast    = m_tvalid && (r_beat[LOG2_FFT-1:0] == {LOG2_FFT{1'b1}});
  assign m_tuser    = m_tvalid && (32'(w_sym) < 32'(CE_SYM_NUM));
  assign sym_idx    = w_sym;
  assign rd_ptr     = r_rd_ptr;
  assign frame_done = (r_state == S_DONE);

endmodule
